alu_seq_accum: RTL and testbench

//  Parametrised, handshaked sequential ALU with a 2*WIDTH result accumulator.

---
 rtl/alu_seq_accum.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_seq_accum.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_accum.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_accum
// Function : valid/ready sequential ALU with a 2*WIDTH result accumulator;
//            single-cycle logic/arith ops, iterative signed MULT and DIV.
//            Optional macro ALU_SAT_EN: saturating ADD/SUB.
// Revision : 1.0
// ============================================================================
module alu_seq_accum #(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         cmd,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               use_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [2*WIDTH-1:0] acc,
    output logic               overflow,
    output logic               div_by_zero,
    output logic               illegal
);

    localparam int C_RW = 2 * WIDTH;
    localparam int C_CW = $clog2(WIDTH);

    localparam logic [4:0] C_OP_ADD  = 5'd1;
    localparam logic [4:0] C_OP_SUB  = 5'd2;
    localparam logic [4:0] C_OP_MULT = 5'd3;
    localparam logic [4:0] C_OP_DIV  = 5'd4;
    localparam logic [4:0] C_OP_SR   = 5'd5;
    localparam logic [4:0] C_OP_SL   = 5'd6;
    localparam logic [4:0] C_OP_AND  = 5'd7;
    localparam logic [4:0] C_OP_OR   = 5'd8;
    localparam logic [4:0] C_OP_XOR  = 5'd9;
    localparam logic [4:0] C_OP_NOT  = 5'd10;
    localparam logic [4:0] C_OP_NAND = 5'd11;
    localparam logic [4:0] C_OP_NOR  = 5'd12;
    localparam logic [4:0] C_OP_NXOR = 5'd13;

    localparam logic [WIDTH-1:0] C_SHIFT_LIM = WIDTH'(C_RW);
    localparam logic [C_CW-1:0]  C_LAST_ITER = C_CW'(WIDTH - 1);
    localparam logic [C_RW-1:0]  C_SAT_POS   = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [C_RW-1:0]  C_SAT_NEG   = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [C_RW-1:0]   result_q, result_d;
    logic [C_RW-1:0]   acc_q, acc_d;
    logic              overflow_q, overflow_d;
    logic              dbz_q, dbz_d;
    logic              illegal_q, illegal_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic [WIDTH-1:0]  mag_b_q, mag_b_d;
    logic [C_RW-1:0]   work_q, work_d;
    logic [C_CW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]  w_b_eff;
    logic [WIDTH-1:0]  w_mag_a;
    logic [WIDTH-1:0]  w_mag_b;
    logic [WIDTH:0]    w_arith;
    logic [C_RW-1:0]   w_a_ext;
    logic              w_shift_big;
    logic [C_RW-1:0]   w_alu_res;
    logic              w_alu_ovf;
    logic              w_alu_ill;
    logic [WIDTH:0]    w_mul_sum;
    logic [C_RW-1:0]   w_mul_next;
    logic [WIDTH:0]    w_div_rem;
    logic [WIDTH:0]    w_div_trial;
    logic [C_RW-1:0]   w_div_next;
    logic [C_RW-1:0]   w_step;
    logic [C_RW-1:0]   w_quot;
    logic [C_RW-1:0]   w_final;

    assign w_b_eff     = use_acc ? acc_q[WIDTH-1:0] : b;
    assign w_mag_a     = a[WIDTH-1] ? -a : a;
    assign w_mag_b     = w_b_eff[WIDTH-1] ? -w_b_eff : w_b_eff;
    assign w_arith     = (cmd == C_OP_SUB) ? ({a[WIDTH-1], a} - {w_b_eff[WIDTH-1], w_b_eff})
                                           : ({a[WIDTH-1], a} + {w_b_eff[WIDTH-1], w_b_eff});
    assign w_a_ext     = {{WIDTH{1'b0}}, a};
    assign w_shift_big = (w_b_eff >= C_SHIFT_LIM);

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_ill = 1'b0;
        case (cmd)
            C_OP_ADD, C_OP_SUB: begin
                w_alu_ovf = w_arith[WIDTH] ^ w_arith[WIDTH-1];
                w_alu_res = {{(WIDTH-1){w_arith[WIDTH]}}, w_arith};
`ifdef ALU_SAT_EN
                if (w_alu_ovf) begin
                    w_alu_res = w_arith[WIDTH] ? C_SAT_NEG : C_SAT_POS;
                end
`endif
            end
            C_OP_MULT, C_OP_DIV: begin
                w_alu_res = '0;
            end
            C_OP_SR:   w_alu_res = w_shift_big ? '0 : (w_a_ext >> w_b_eff);
            C_OP_SL:   w_alu_res = w_shift_big ? '0 : (w_a_ext << w_b_eff);
            C_OP_AND:  w_alu_res = {{WIDTH{1'b0}}, a & w_b_eff};
            C_OP_OR:   w_alu_res = {{WIDTH{1'b0}}, a | w_b_eff};
            C_OP_XOR:  w_alu_res = {{WIDTH{1'b0}}, a ^ w_b_eff};
            C_OP_NOT:  w_alu_res = {{WIDTH{1'b0}}, ~a};
            C_OP_NAND: w_alu_res = {{WIDTH{1'b0}}, ~(a & w_b_eff)};
            C_OP_NOR:  w_alu_res = {{WIDTH{1'b0}}, ~(a | w_b_eff)};
            C_OP_NXOR: w_alu_res = {{WIDTH{1'b0}}, ~(a ^ w_b_eff)};
            default:   w_alu_ill = 1'b1;
        endcase
    end

    // Unsigned magnitude engines; sign is restored from neg_q on the last step.
    // MULT: work = {partial product, remaining multiplier}, shift-add.
    assign w_mul_sum  = {1'b0, work_q[C_RW-1:WIDTH]} + {1'b0, mag_b_q};
    assign w_mul_next = work_q[0] ? {w_mul_sum, work_q[WIDTH-1:1]}
                                  : {1'b0, work_q[C_RW-1:1]};

    // DIV: work = {remainder, dividend/quotient}, restoring division.
    assign w_div_rem   = {work_q[C_RW-1:WIDTH], work_q[WIDTH-1]};
    assign w_div_trial = w_div_rem - {1'b0, mag_b_q};
    assign w_div_next  = w_div_trial[WIDTH]
                       ? {w_div_rem[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0}
                       : {w_div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};

    assign w_step  = is_div_q ? w_div_next : w_mul_next;
    assign w_quot  = {{WIDTH{1'b0}}, w_step[WIDTH-1:0]};
    assign w_final = is_div_q ? (neg_q ? -w_quot : w_quot)
                              : (neg_q ? -w_step : w_step);

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        acc_d      = acc_q;
        overflow_d = overflow_q;
        dbz_d      = dbz_q;
        illegal_d  = illegal_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        mag_b_d    = mag_b_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    overflow_d = 1'b0;
                    dbz_d      = 1'b0;
                    illegal_d  = 1'b0;
                    if ((cmd == C_OP_MULT) || ((cmd == C_OP_DIV) && (w_b_eff != '0))) begin
                        state_d  = S_BUSY;
                        is_div_d = (cmd == C_OP_DIV);
                        neg_d    = a[WIDTH-1] ^ w_b_eff[WIDTH-1];
                        mag_b_d  = w_mag_b;
                        work_d   = {{WIDTH{1'b0}}, w_mag_a};
                        cnt_d    = '0;
                    end else begin
                        state_d = S_DONE;
                        if (cmd == C_OP_DIV) begin
                            result_d = '0;
                            acc_d    = '0;
                            dbz_d    = 1'b1;
                        end else if (w_alu_ill) begin
                            result_d  = '0;
                            illegal_d = 1'b1;
                        end else begin
                            result_d   = w_alu_res;
                            acc_d      = w_alu_res;
                            overflow_d = w_alu_ovf;
                        end
                    end
                end
            end
            S_BUSY: begin
                work_d = w_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == C_LAST_ITER) begin
                    state_d  = S_DONE;
                    result_d = w_final;
                    acc_d    = w_final;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
            illegal_q   <= 1'b0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            mag_b_q     <= '0;
            work_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
            illegal_q   <= illegal_d;
            is_div_q    <= is_div_d;
            neg_q       <= neg_d;
            mag_b_q     <= mag_b_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign acc         = acc_q;
    assign overflow    = overflow_q;
    assign div_by_zero = dbz_q;
    assign illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_accum
// Function : directed, table-driven bench for alu_seq_accum (WIDTH=16).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq_accum;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [4:0]     cmd;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           use_acc;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic [2*W-1:0] acc;
    logic           overflow;
    logic           div_by_zero;
    logic           illegal;

    alu_seq_accum #(.WIDTH(W)) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cmd         (cmd),
        .a           (a),
        .b           (b),
        .use_acc     (use_acc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .acc         (acc),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]     cmd;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           use_acc;
        logic [2*W-1:0] res;
        logic           ovf;
        logic           dbz;
        logic           ill;
        int             lat;
    } vec_t;

    vec_t           vecs[$];
    int             passed = 0;
    int             total  = 0;
    logic [2*W-1:0] exp_acc;
    int             lat;

    function automatic vec_t mk(input logic [4:0] c, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic ua, input logic [2*W-1:0] r, input logic o,
                                input logic z, input logic i, input int l);
        vec_t v;
        v.cmd = c; v.a = va; v.b = vb; v.use_acc = ua; v.res = r;
        v.ovf = o; v.dbz = z; v.ill = i; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Offer one command, scramble inputs after the accept edge, wait for out_valid.
    task automatic issue(input logic [4:0] c, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic ua, output int l);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("in_ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1; cmd = c; a = va; b = vb; use_acc = ua;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cmd = 5'($urandom); a = W'($urandom); b = W'($urandom); use_acc = ~ua;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!out_valid && l < 100);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cmd = '0; a = '0; b = '0; use_acc = 1'b0;
        exp_acc = '0;

        vecs.push_back(mk(5'd1,  16'd10,   16'd20,   1'b0, 32'd30,       1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd2,  16'd50,   16'd999,  1'b1, 32'd20,       1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd3,  16'hFED4, 16'd200,  1'b0, 32'hFFFF15A0, 1'b0, 1'b0, 1'b0, 17));
        vecs.push_back(mk(5'd4,  16'hFFF9, 16'd2,    1'b0, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0, 17));
        vecs.push_back(mk(5'd20, 16'd1,    16'd2,    1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(5'd4,  16'd5,    16'd0,    1'b0, 32'd0,        1'b0, 1'b1, 1'b0, 1));
`ifdef ALU_SAT_EN
        vecs.push_back(mk(5'd1,  16'd30000, 16'd30000, 1'b0, 32'h00007FFF, 1'b1, 1'b0, 1'b0, 1));
`else
        vecs.push_back(mk(5'd1,  16'd30000, 16'd30000, 1'b0, 32'h0000EA60, 1'b1, 1'b0, 1'b0, 1));
`endif
        vecs.push_back(mk(5'd6,  16'd16,   16'd2,    1'b0, 32'd64,       1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd5,  16'd16,   16'd40,   1'b0, 32'd0,        1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd5,  16'h8000, 16'd3,    1'b0, 32'h00001000, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd6,  16'h8001, 16'd16,   1'b0, 32'h80010000, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd7,  16'hF0F0, 16'h3C3C, 1'b0, 32'h00003030, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd8,  16'hF0F0, 16'h3C3C, 1'b0, 32'h0000FCFC, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd9,  16'hF0F0, 16'h3C3C, 1'b0, 32'h0000CCCC, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd10, 16'h00FF, 16'h1234, 1'b0, 32'h0000FF00, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd11, 16'hF0F0, 16'h3C3C, 1'b0, 32'h0000CFCF, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd12, 16'hF0F0, 16'h3C3C, 1'b0, 32'h00000303, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd13, 16'hF0F0, 16'h3C3C, 1'b0, 32'h00003333, 1'b0, 1'b0, 1'b0, 1));
`ifdef ALU_SAT_EN
        vecs.push_back(mk(5'd2,  16'h8000, 16'd1,    1'b0, 32'hFFFF8000, 1'b1, 1'b0, 1'b0, 1));
`else
        vecs.push_back(mk(5'd2,  16'h8000, 16'd1,    1'b0, 32'hFFFF7FFF, 1'b1, 1'b0, 1'b0, 1));
`endif
        vecs.push_back(mk(5'd3,  16'h8000, 16'h8000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0, 17));
        vecs.push_back(mk(5'd4,  16'h8000, 16'hFFFF, 1'b0, 32'h00008000, 1'b0, 1'b0, 1'b0, 17));
        vecs.push_back(mk(5'd3,  16'd3,    16'd0,    1'b1, 32'hFFFE8000, 1'b0, 1'b0, 1'b0, 17));
        vecs.push_back(mk(5'd4,  16'd100,  16'hFFF9, 1'b0, 32'hFFFFFFF2, 1'b0, 1'b0, 1'b0, 17));
        vecs.push_back(mk(5'd1,  16'hFFFB, 16'd3,    1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(5'd0,  16'd4,    16'd4,    1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(5'd2,  16'd5,    16'd0,    1'b1, 32'd7,        1'b0, 1'b0, 1'b0, 1));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready",  64'(in_ready),    64'd1);
        check("reset_out_valid", 64'(out_valid),   64'd0);
        check("reset_result",    64'(result),      64'd0);
        check("reset_acc",       64'(acc),         64'd0);
        check("reset_flags",     64'({overflow, div_by_zero, illegal}), 64'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].use_acc, lat);
            if (!vecs[i].ill) exp_acc = vecs[i].res;
            check($sformatf("v%0d_latency", i),  64'(lat),         64'(vecs[i].lat));
            check($sformatf("v%0d_result", i),   64'(result),      64'(vecs[i].res));
            check($sformatf("v%0d_acc", i),      64'(acc),         64'(exp_acc));
            check($sformatf("v%0d_overflow", i), 64'(overflow),    64'(vecs[i].ovf));
            check($sformatf("v%0d_dbz", i),      64'(div_by_zero), 64'(vecs[i].dbz));
            check($sformatf("v%0d_illegal", i),  64'(illegal),     64'(vecs[i].ill));
            drain();
        end

        // Stall in DONE for three cycles while a new command is offered.
        issue(5'd1, 16'd100, 16'd23, 1'b0, lat);
        check("stall_first_result", 64'(result), 64'd123);
        in_valid = 1'b1; cmd = 5'd1; a = 16'd5; b = 16'd5; use_acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_result", k),    64'(result),    64'd123);
            check($sformatf("stall%0d_in_ready", k),  64'(in_ready),  64'd0);
            check($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'd1);
        end
        // out_ready and in_valid together: drain only, accept on the next IDLE edge.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("drain_in_ready",  64'(in_ready),  64'd1);
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_acc_kept",  64'(acc),       64'd123);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("next_out_valid", 64'(out_valid), 64'd1);
        check("next_result",    64'(result),    64'd10);
        check("next_acc",       64'(acc),       64'd10);
        drain();

        // Reset asserted on BUSY cycle 4 of a MULT.
        @(negedge clk);
        in_valid = 1'b1; cmd = 5'd3; a = 16'd3; b = 16'd5; use_acc = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_acc",       64'(acc),       64'd0);
        check("abort_result",    64'(result),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready",  64'(in_ready),  64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        issue(5'd1, 16'd7, 16'd9, 1'b1, lat);
        check("post_reset_add_acc", 64'(result), 64'd7);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
